// File: rtl/raw_bin_seq_ctrl.sv
// Sequencer for the 2x2 Bayer binning stage. It owns the one-line buffer, presents
// D0/D1/X/Y, and emits valid/SOF/EOL qualifiers aligned with the stage's registered RGB.
module raw_bin_seq_ctrl #(
    parameter int LINE_W = 640,
    parameter int PIX_W  = 10,
    parameter bit X_INV  = 1'b0,
    parameter bit Y_INV  = 1'b0
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      in_fval,
    input  logic                      in_lval,
    input  logic [PIX_W-1:0]          in_data,
    input  logic                      decim,
    output logic [PIX_W-1:0]          D0,
    output logic [PIX_W-1:0]          D1,
    output logic                      X,
    output logic                      Y,
    output logic                      rgb_valid,
    output logic                      rgb_sof,
    output logic                      rgb_eol,
    output logic [$clog2(LINE_W)-1:0] h_cnt,
    output logic [11:0]               v_cnt,
    output logic                      err_ovf
);
    localparam int AW  = $clog2(LINE_W);
    localparam int HCW = $clog2(LINE_W + 1);
    localparam logic [HCW-1:0] H_MAX = HCW'(LINE_W);
    localparam logic [11:0]    V_MAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, GAP} state_t;

    state_t state_q, state_d;

    logic            fval_q;
    logic            decim_q, decim_d;
    logic            sof_pend_q, sof_pend_d;
    logic            err_q, err_d;
    logic [HCW-1:0]  h_q, h_d;
    logic [11:0]     v_q, v_d;

    logic            frame_start, accept, line_end;
    logic            wr_en, ovf;
    logic [AW-1:0]   waddr;

    logic [PIX_W-1:0] d0_q, d1_q;
    logic             x_q, y_q, pix_v_q;
    logic [AW-1:0]    hc_q;
    logic [11:0]      vc_q;
    logic             vld_q, vld_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;

    logic [PIX_W-1:0] mem [LINE_W];

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (in_fval && !fval_q) state_d = WAIT_LINE;
            WAIT_LINE: if (!in_fval)      state_d = IDLE;
                       else if (in_lval)  state_d = ACTIVE;
            ACTIVE:    if (!in_fval)      state_d = IDLE;
                       else if (!in_lval) state_d = GAP;
            GAP:       if (!in_fval)      state_d = IDLE;
                       else if (in_lval)  state_d = ACTIVE;
            default:   state_d = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        frame_start = 1'b0;
        accept      = 1'b0;
        line_end    = 1'b0;
        case (state_q)
            IDLE:           frame_start = in_fval & ~fval_q;
            WAIT_LINE, GAP: accept      = in_fval & in_lval;
            ACTIVE: begin
                accept   = in_fval & in_lval;
                line_end = in_fval & ~in_lval;
            end
            default: ;
        endcase
    end

    assign wr_en = accept & (h_q != H_MAX);
    assign ovf   = accept & (h_q == H_MAX);
    assign waddr = h_q[AW-1:0];

    // Every non-accepting cycle is either a line boundary or outside a line, so h restarts.
    always_comb begin
        h_d        = '0;
        v_d        = v_q;
        decim_d    = decim_q;
        err_d      = err_q;
        sof_pend_d = sof_pend_q;
        if (accept) h_d = (h_q == H_MAX) ? h_q : h_q + HCW'(1);
        if (frame_start) begin
            v_d        = '0;
            decim_d    = decim;
            err_d      = 1'b0;
            sof_pend_d = 1'b1;
        end else begin
            if (line_end && v_q != V_MAX) v_d = v_q + 12'd1;
            if (ovf)                      err_d = 1'b1;
            if (vld_d)                    sof_pend_d = 1'b0;
        end
    end

    // Row 0 and column 0 lack a neighbour; decimation keeps only the odd/odd corner.
    always_comb begin
        vld_d = pix_v_q & (vc_q != '0) & (hc_q != '0) &
                (~decim_q | (hc_q[0] & vc_q[0]));
        sof_d = vld_d & sof_pend_q;
        eol_d = vld_d & line_end;
    end

    // fval_q resets high so a frame already in progress at reset release is ignored.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fval_q     <= 1'b1;
            decim_q    <= 1'b0;
            sof_pend_q <= 1'b0;
            err_q      <= 1'b0;
            h_q        <= '0;
            v_q        <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
            x_q        <= 1'b0;
            y_q        <= 1'b0;
            hc_q       <= '0;
            vc_q       <= '0;
            pix_v_q    <= 1'b0;
            vld_q      <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            fval_q     <= in_fval;
            decim_q    <= decim_d;
            sof_pend_q <= sof_pend_d;
            err_q      <= err_d;
            h_q        <= h_d;
            v_q        <= v_d;
            pix_v_q    <= wr_en;
            if (wr_en) begin
                d0_q <= in_data;
                d1_q <= mem[waddr];
                x_q  <= h_q[0] ^ X_INV;
                y_q  <= v_q[0] ^ Y_INV;
                hc_q <= waddr;
                vc_q <= v_q;
            end
            vld_q <= vld_d;
            sof_q <= sof_d;
            eol_q <= eol_d;
        end
    end

    // Line buffer: no reset; the read above sees the previous line at this column.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[waddr] <= in_data;
    end

    assign D0        = d0_q;
    assign D1        = d1_q;
    assign X         = x_q;
    assign Y         = y_q;
    assign rgb_valid = vld_q;
    assign rgb_sof   = sof_q;
    assign rgb_eol   = eol_q;
    assign h_cnt     = hc_q;
    assign v_cnt     = vc_q;
    assign err_ovf   = err_q;

endmodule

// File: tb/tb_raw_bin_seq_ctrl.sv
// Bench for raw_bin_seq_ctrl: directed frames plus random frames, each checked
// cycle-by-cycle against a pixel-level reference model (rows, columns, line buffer).
module tb_raw_bin_seq_ctrl;
    localparam int LW = 16;
    localparam int PW = 10;
    localparam int NC = 16384;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic in_fval = 1'b0, in_lval = 1'b0, decim = 1'b0;
    logic [PW-1:0] in_data = '0;

    logic [PW-1:0] d0a, d1a, d0b, d1b;
    logic xa, ya, xb, yb, va, vb, sofa, sofb, eola, eolb, erra, errb;
    logic [3:0]  ha, hb;
    logic [11:0] vca, vcb;

    raw_bin_seq_ctrl #(.LINE_W(LW), .PIX_W(PW), .X_INV(1'b0), .Y_INV(1'b0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .in_fval(in_fval), .in_lval(in_lval),
        .in_data(in_data), .decim(decim), .D0(d0a), .D1(d1a), .X(xa), .Y(ya),
        .rgb_valid(va), .rgb_sof(sofa), .rgb_eol(eola), .h_cnt(ha), .v_cnt(vca),
        .err_ovf(erra));

    raw_bin_seq_ctrl #(.LINE_W(LW), .PIX_W(PW), .X_INV(1'b1), .Y_INV(1'b1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .in_fval(in_fval), .in_lval(in_lval),
        .in_data(in_data), .decim(decim), .D0(d0b), .D1(d1b), .X(xb), .Y(yb),
        .rgb_valid(vb), .rgb_sof(sofb), .rgb_eol(eolb), .h_cnt(hb), .v_cnt(vcb),
        .err_ovf(errb));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_val, n_sof, n_eol;

    // Expectations indexed by clock edge number
    bit          e1_v [NC];
    bit          e1_k [NC];
    logic [PW-1:0] e1_d0 [NC];
    logic [PW-1:0] e1_d1 [NC];
    int          e1_h [NC];
    int          e1_r [NC];
    bit          e2_v [NC];
    bit          e2_sof [NC];
    bit          e2_eol [NC];
    bit          e_err [NC];

    logic [PW-1:0] lbuf [LW];
    bit            lknown [LW];
    bit in_frame = 1'b0, prev_fv = 1'b1, dec_m = 1'b0, err_m = 1'b0, sof_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_D0"}, d0a, 0);   chk({tag, "_D1"}, d1a, 0);
        chk({tag, "_X"}, xa, 0);     chk({tag, "_Y"}, ya, 0);
        chk({tag, "_val"}, va, 0);   chk({tag, "_sof"}, sofa, 0);
        chk({tag, "_eol"}, eola, 0); chk({tag, "_h"}, ha, 0);
        chk({tag, "_v"}, vca, 0);    chk({tag, "_err"}, erra, 0);
        chk({tag, "_Xinv"}, xb, 0);  chk({tag, "_Yinv"}, yb, 0);
    endtask

    // One clock: drive inputs, predict from pixel coordinates, then check after the edge
    task automatic step(input bit fv, input bit lv, input logic [PW-1:0] d, input bit dec,
                        input int r, input int c, input bit last);
        int k;
        bit acc, val;
        k = cyc + 1;
        in_fval = fv; in_lval = lv; in_data = d; decim = dec;
        acc = 1'b0;
        if (!RESET_N) begin
            in_frame = 1'b0; prev_fv = 1'b1; err_m = 1'b0; sof_pend = 1'b0;
        end else begin
            acc = in_frame && fv && lv;
            if (!fv) in_frame = 1'b0;
            else if (!in_frame && !prev_fv) begin
                in_frame = 1'b1; dec_m = dec; err_m = 1'b0; sof_pend = 1'b1;
            end
            prev_fv = fv;
        end
        if (acc) begin
            if (c >= LW) err_m = 1'b1;
            else begin
                e1_v[k] = 1'b1; e1_d0[k] = d; e1_d1[k] = lbuf[c]; e1_k[k] = lknown[c];
                e1_h[k] = c; e1_r[k] = r;
                lbuf[c] = d; lknown[c] = 1'b1;
                val = (r >= 1) && (c >= 1) && (!dec_m || ((r % 2 == 1) && (c % 2 == 1)));
                e2_v[k+1] = val;
                e2_sof[k+1] = val && sof_pend;
                e2_eol[k+1] = val && last;
                if (val) sof_pend = 1'b0;
            end
        end
        e_err[k] = err_m;
        @(posedge CLK);
        #1;
        cyc = k;
        chk("rgb_valid", va, e2_v[k]);   chk("rgb_valid_inv", vb, e2_v[k]);
        chk("rgb_sof", sofa, e2_sof[k]); chk("rgb_sof_inv", sofb, e2_sof[k]);
        chk("rgb_eol", eola, e2_eol[k]); chk("rgb_eol_inv", eolb, e2_eol[k]);
        chk("err_ovf", erra, e_err[k]);  chk("err_ovf_inv", errb, e_err[k]);
        if (e1_v[k]) begin
            chk("D0", d0a, e1_d0[k]);  chk("D0_inv", d0b, e1_d0[k]);
            if (e1_k[k]) begin
                chk("D1", d1a, e1_d1[k]); chk("D1_inv", d1b, e1_d1[k]);
            end
            chk("X", xa, e1_h[k] % 2);        chk("Y", ya, e1_r[k] % 2);
            chk("X_inv", xb, 1 - (e1_h[k] % 2)); chk("Y_inv", yb, 1 - (e1_r[k] % 2));
            chk("h_cnt", ha, e1_h[k]);  chk("h_cnt_inv", hb, e1_h[k]);
            chk("v_cnt", vca, e1_r[k]); chk("v_cnt_inv", vcb, e1_r[k]);
        end
        if (va)   n_val++;
        if (sofa) n_sof++;
        if (eola) n_eol++;
    endtask

    // A frame of nrows lines; len=0 picks random lengths; ovf_row gets LW+3 pixels;
    // fval drops at (ab_row, ab_col) when ab_row >= 0.
    task automatic frame(input int nrows, input int len, input bit dec, input bit rnd,
                         input int ovf_row, input int ab_row, input int ab_col);
        int L, g;
        logic [PW-1:0] d;
        bit done;
        done = 1'b0;
        n_val = 0; n_sof = 0; n_eol = 0;
        step(1'b1, 1'b0, '0, dec, 0, 0, 1'b0);
        step(1'b1, 1'b0, '0, 1'($urandom), 0, 0, 1'b0);
        for (int r = 0; r < nrows && !done; r++) begin
            L = (r == ovf_row) ? LW + 3 : ((len > 0) ? len : int'($urandom_range(LW, 2)));
            for (int c = 0; c < L; c++) begin
                d = rnd ? PW'($urandom) : PW'(r * 16 + c);
                if (r == ab_row && c == ab_col) begin
                    step(1'b0, 1'b1, d, 1'($urandom), r, c, 1'b0);
                    done = 1'b1;
                    break;
                end
                step(1'b1, 1'b1, d, 1'($urandom), r, c, c == L - 1);
            end
            if (!done) begin
                g = rnd ? int'($urandom_range(3, 1)) : 1;
                repeat (g) step(1'b1, 1'b0, '0, 1'($urandom), 0, 0, 1'b0);
            end
        end
        repeat (4) step(1'b0, 1'b0, '0, 1'($urandom), 0, 0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        #2 RESET_N = 1'b1;
        repeat (3) step(1'b0, 1'b0, '0, 1'b0, 0, 0, 1'b0);

        // 4x8 full rate
        frame(4, 8, 1'b0, 1'b0, -1, -1, -1);
        chk("full_nvalid", n_val, 21); chk("full_nsof", n_sof, 1); chk("full_neol", n_eol, 3);

        // 4x8 decimated
        frame(4, 8, 1'b1, 1'b0, -1, -1, -1);
        chk("dec_nvalid", n_val, 8); chk("dec_nsof", n_sof, 1); chk("dec_neol", n_eol, 2);

        // Overflowing line 1, then a full-width line reading it back
        frame(3, LW, 1'b0, 1'b1, 1, -1, -1);
        chk("ovf_nvalid", n_val, 30); chk("ovf_neol", n_eol, 1);
        chk("ovf_sticky", erra, 1);

        // Abort mid line 2 at col 4, then a clean restart
        frame(4, 8, 1'b0, 1'b0, -1, 2, 4);
        chk("abort_nvalid", n_val, 10); chk("abort_neol", n_eol, 1);
        frame(2, 8, 1'b0, 1'b1, -1, -1, -1);
        chk("restart_nvalid", n_val, 7); chk("restart_nsof", n_sof, 1);

        // Asynchronous reset in the middle of line 1
        step(1'b1, 1'b0, '0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 0, 0, 1'b0);
        for (int c = 0; c < 8; c++) step(1'b1, 1'b1, PW'($urandom), 1'b0, 0, c, c == 7);
        step(1'b1, 1'b0, '0, 1'b0, 0, 0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, PW'($urandom), 1'b0, 1, c, 1'b0);
        #2 RESET_N = 1'b0;
        #1;
        chk_all_zero("async_rst");
        e2_v[cyc+1] = 1'b0; e2_sof[cyc+1] = 1'b0; e2_eol[cyc+1] = 1'b0;
        e2_v[cyc+2] = 1'b0; e2_sof[cyc+2] = 1'b0; e2_eol[cyc+2] = 1'b0;
        repeat (2) step(1'b1, 1'b1, PW'($urandom), 1'b0, 1, 5, 1'b0);
        #2 RESET_N = 1'b1;
        n_val = 0;
        repeat (4) step(1'b1, 1'b1, PW'($urandom), 1'b0, 1, 6, 1'b0);
        repeat (2) step(1'b1, 1'b0, '0, 1'b0, 0, 0, 1'b0);
        chk("post_rst_nvalid", n_val, 0);
        repeat (3) step(1'b0, 1'b0, '0, 1'b0, 0, 0, 1'b0);
        frame(2, 8, 1'b0, 1'b1, -1, -1, -1);
        chk("post_rst_frame_nvalid", n_val, 7);

        // Random frames: random lengths, gaps, data, decimation, occasional overflow/abort
        for (int i = 0; i < 8; i++) begin
            frame(int'($urandom_range(6, 2)), 0, 1'($urandom), 1'b1,
                  (i % 3 == 2) ? 1 : -1,
                  (i % 4 == 3) ? 1 : -1, int'($urandom_range(7, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/raw_bin_seq_ctrl.md
Name: raw_bin_seq_ctrl

Overview:
- Sequencer for the 2x2 Bayer-to-RGB binning datapath.
- Accepts the raw D8M pixel stream (frame/line valid, 10-bit data) and owns a one-line buffer.
- Presents current-line pixel D0, previous-line pixel D1, column parity X and row parity Y to the binning stage.
- Generates the valid/SOF/EOL qualifiers that align with that stage's 1-cycle registered RGB output; supports full-rate or 2x2-decimated output.

Parameters:
- LINE_W, 640: maximum active pixels per line (line buffer depth).
- PIX_W, 10: raw pixel width.
- X_INV, 0: inverts the X parity to match sensor Bayer phase.
- Y_INV, 0: inverts the Y parity to match sensor Bayer phase.

Ports:
- CLK  in  1  pixel clock
- RESET_N  in  1  asynchronous, active-low reset
- in_fval  in  1  frame valid
- in_lval  in  1  line valid; a pixel is accepted each cycle in_fval&in_lval=1
- in_data  in  PIX_W  raw Bayer pixel
- decim  in  1  0=full-rate output, 1=2x2 decimated (one RGB per quad); sampled at frame start only
- D0  out  PIX_W  current-line pixel to binning stage
- D1  out  PIX_W  previous-line pixel, same column, to binning stage
- X  out  1  column parity to binning stage
- Y  out  1  row parity to binning stage
- rgb_valid  out  1  binning-stage R/G/B valid this cycle
- rgb_sof  out  1  first valid RGB of frame
- rgb_eol  out  1  last valid RGB of line
- h_cnt  out  clog2(LINE_W)  column of pixel currently on D0
- v_cnt  out  12  row of pixel currently on D0
- err_ovf  out  1  sticky: line exceeded LINE_W

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters 0, decim latch 0. Line buffer contents are not reset.
- FSM states:
  - IDLE: in_fval rising edge -> WAIT_LINE. Clears v_cnt and err_ovf; latches decim.
  - WAIT_LINE: in_lval=1 -> ACTIVE (first pixel accepted this cycle, h_cnt=0).
  - ACTIVE: in_lval falling -> GAP, v_cnt+1, h_cnt cleared.
  - GAP: in_lval=1 -> ACTIVE.
  - in_fval=0 in any non-IDLE state -> IDLE. The current line is aborted; no rgb_eol for the partial line; the pipeline drains (already-issued valids complete).
- Stage 1, cycle t+1 after a pixel is accepted at t:
  - D0 = in_data(t); D1 = line buffer read at column h.
  - X = h[0]^X_INV; Y = v[0]^Y_INV.
  - Buffer write of in_data(t) at column h happens at t; read-before-write at the same address returns the previous line.
  - pix_v (internal) = 1.
- Stage 2, cycle t+2, aligned with the binning stage's registered R/G/B:
  - rgb_valid = pix_v(t+1) & v>=1 & h>=1. Row 0 and column 0 are never valid: no previous line or previous column exists.
  - When decim=1, additionally requires h[0]=1 & v[0]=1, i.e. one output per 2x2 quad.
- rgb_sof: first rgb_valid after IDLE->WAIT_LINE.
- rgb_eol: on the rgb_valid of the last accepted pixel of a line. Last pixel is detected by in_lval falling, so the stage-2 flag is held one extra cycle; rgb_eol may coincide with the last rgb_valid only.
- Overflow: pixel accepted with h=LINE_W -> dropped (no buffer write, no pix_v); err_ovf set, held until next frame start.
- Short lines: columns beyond the current length keep stale data and are never read in that line.
- Back-to-back lines with a 1-cycle gap are supported.
- Throughput: 1 pixel/cycle, no backpressure.
- Arithmetic: counters saturate; v_cnt does not wrap within a frame.

Test Plan:
- Frame 4 lines x 8 pixels, data=row*16+col, decim=0:
  - rgb_valid count = 3x7 = 21.
  - First valid at row1 col1 with D0=0x11, D1=0x01 one cycle earlier; X/Y = 1/1.
  - rgb_sof once; rgb_eol 3 times.
- Same frame, decim=1:
  - rgb_valid only at (1,1),(1,3),(1,5),(1,7),(3,1)…(3,7) = 8 pulses.
  - rgb_eol at (1,7) and (3,7).
- X_INV=1, Y_INV=1: X/Y on the (1,1) pixel read 0/0; rgb_valid pattern unchanged.
- Line of LINE_W+3 pixels:
  - Last 3 pixels dropped; err_ovf=1 through frame end; cleared at next in_fval rise.
  - Next line reads D1 correctly at columns 0..LINE_W-1.
- in_fval dropped mid-line 2 at col 4:
  - No rgb_eol for that line; rgb_valid stops within 2 cycles; FSM=IDLE.
  - Next frame restarts with v_cnt=0 and no valid on row 0.
- RESET_N asserted mid-line: all outputs 0 immediately (asynchronous); after release, FSM waits for a fresh in_fval rise even if in_fval is already high.
